// File: rtl/pc_sequencer_if.sv
// Control-unit to program-counter-sequencer bus: op request in, fetch address and status out.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 8
);
    logic                             en;
    logic [2:0]                       op;
    logic [WIDTH-1:0]                 target;
    logic                             cond;
    logic [WIDTH-1:0]                 pc;
    logic [$clog2(STACK_DEPTH+1)-1:0] depth;
    logic                             fault;

    modport master (
        output en, op, target, cond,
        input  pc, depth, fault
    );

    modport slave (
        input  en, op, target, cond,
        output pc, depth, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: NEXT/HOLD/JUMP/BRANCH/CALL/RET with sticky fault state.
// Return-address stack is compiled in only when PC_RETURN_STACK_EN is defined.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      STACK_DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [DW-1:0]    depth_q;

`ifdef PC_RETURN_STACK_EN
    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DW-1:0]    depth_d;
    logic             push;
    logic [AW-1:0]    push_idx, pop_idx;
    logic [WIDTH-1:0] stack [STACK_DEPTH];

    assign push_idx = AW'(depth_q);
    assign pop_idx  = AW'(depth_q - DW'(1));
`else
    assign depth_q = '0;
`endif

    assign pc_inc = pc_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_RETURN_STACK_EN
        depth_d = depth_q;
        push    = 1'b0;
`endif
        // Faulting cycles only move the state; pc and stack stay put.
        if (state_q == S_RUN && bus.en) begin
            case (bus.op)
                3'b000: pc_d = pc_inc;
                3'b001: pc_d = pc_q;
                3'b010: pc_d = bus.target;
                3'b011: pc_d = bus.cond ? bus.target : pc_inc;
`ifdef PC_RETURN_STACK_EN
                3'b100: begin
                    if (depth_q == DW'(STACK_DEPTH)) begin
                        state_d = S_FAULT;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        pc_d    = bus.target;
                    end
                end
                3'b101: begin
                    if (depth_q == '0) begin
                        state_d = S_FAULT;
                    end else begin
                        depth_d = depth_q - DW'(1);
                        pc_d    = stack[pop_idx];
                    end
                end
`else
                3'b100: pc_d = bus.target;
`endif
                default: state_d = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VECTOR;
`ifdef PC_RETURN_STACK_EN
            depth_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_RETURN_STACK_EN
            depth_q <= depth_d;
`endif
        end
    end

`ifdef PC_RETURN_STACK_EN
    // Storage needs no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= pc_inc;
        end
    end
`endif

    assign bus.pc    = pc_q;
    assign bus.depth = depth_q;
    assign bus.fault = (state_q == S_FAULT);
endmodule
